// File: rtl/round_sequencer_if.sv
// Handshake bundle between the round sequencer and the puzzle handler.
// The master side drives handler control; the slave side answers.
interface round_sequencer_if;
  logic       hs_rst_n;
  logic       hs_start;
  logic       hs_change;
  logic [1:0] hs_mode;
  logic [3:0] hs_addr;
  logic       hs_en;
  logic       hs_correct;

  modport master (
    output hs_rst_n, hs_start, hs_change, hs_mode, hs_addr,
    input  hs_en, hs_correct
  );

  modport slave (
    input  hs_rst_n, hs_start, hs_change, hs_mode, hs_addr,
    output hs_en, hs_correct
  );
endinterface

// File: rtl/round_sequencer.sv
// Game-round controller: sequences handler load/scramble/play, counts moves
// and seconds, keeps score and level, and watches the handler handshake.
module round_sequencer #(
  parameter int         TICK_DIV   = 50_000_000,
  parameter int         MOVE_LIMIT = 15,
  parameter int         ROUND_SECS = 60,
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter int         HS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_btn_start,
  input  logic              i_btn_swap,
  input  logic [1:0]        i_mode_sel,
  round_sequencer_if.master hs,
  output logic [4:0]        o_moves,
  output logic [6:0]        o_secs_left,
  output logic [7:0]        o_score,
  output logic [1:0]        o_status,
  output logic              o_hs_fault
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [4:0]    MOVES_MAX = 5'(MOVE_LIMIT);
  localparam logic [6:0]    SECS_INIT = 7'(ROUND_SECS);
  localparam logic [7:0]    WD_LAST   = 8'(HS_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SHOW,
    S_SCRAMBLE,
    S_PLAY,
    S_SWAP,
    S_CHECK,
    S_WIN,
    S_LOSE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_lfsr;
  logic          r_start_prev;
  logic          r_swap_prev;
  logic          r_start_edge;
  logic          r_swap_edge;
  logic [1:0]    r_level;
  logic [7:0]    r_wd;
  logic [1:0]    r_win;
  logic [TW-1:0] r_tick;
  logic [4:0]    r_moves;
  logic [6:0]    r_secs_left;
  logic [7:0]    r_score;
  logic [1:0]    r_status;
  logic          r_hs_fault;
  logic          r_hs_rst_n;
  logic          r_hs_start;
  logic          r_hs_change;
  logic [1:0]    r_hs_mode;
  logic [3:0]    r_hs_addr;

  logic          w_lfsr_fb;
  logic          w_tick_run;
  logic          w_wd_expired;
  logic [1:0]    w_mode_start;
  logic [1:0]    w_level_up;
  logic [8:0]    w_score_sum;
  logic [7:0]    w_score_next;

  assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_tick_run   = (r_state == S_PLAY) || (r_state == S_SWAP) || (r_state == S_CHECK);
  assign w_wd_expired = (r_wd == WD_LAST);
  assign w_mode_start = (i_mode_sel == 2'd3) ? 2'd2 : i_mode_sel;
  assign w_level_up   = (r_level >= 2'd2) ? 2'd2 : r_level + 2'd1;
  assign w_score_sum  = {1'b0, r_score} + 9'd1 + {7'd0, r_level};
  assign w_score_next = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

  assign hs.hs_rst_n  = r_hs_rst_n;
  assign hs.hs_start  = r_hs_start;
  assign hs.hs_change = r_hs_change;
  assign hs.hs_mode   = r_hs_mode;
  assign hs.hs_addr   = r_hs_addr;
  assign o_moves      = r_moves;
  assign o_secs_left  = r_secs_left;
  assign o_score      = r_score;
  assign o_status     = r_status;
  assign o_hs_fault   = r_hs_fault;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_lfsr       <= LFSR_SEED;
      r_start_prev <= 1'b0;
      r_swap_prev  <= 1'b0;
      r_start_edge <= 1'b0;
      r_swap_edge  <= 1'b0;
      r_level      <= 2'd0;
      r_wd         <= 8'd0;
      r_win        <= 2'd0;
      r_tick       <= '0;
      r_moves      <= 5'd0;
      r_secs_left  <= SECS_INIT;
      r_score      <= 8'd0;
      r_status     <= 2'd0;
      r_hs_fault   <= 1'b0;
      r_hs_rst_n   <= 1'b0;
      r_hs_start   <= 1'b0;
      r_hs_change  <= 1'b0;
      r_hs_mode    <= 2'd0;
      r_hs_addr    <= 4'd0;
    end else begin
      r_lfsr       <= {r_lfsr[6:0], w_lfsr_fb};
      r_start_prev <= i_btn_start;
      r_swap_prev  <= i_btn_swap;
      r_start_edge <= i_btn_start & ~r_start_prev;
      r_swap_edge  <= i_btn_swap & ~r_swap_prev;
      r_hs_rst_n   <= 1'b1;
      r_hs_start   <= 1'b0;
      r_hs_change  <= 1'b0;

      // Seconds keep running while a swap is in flight; expiry is judged only in PLAY.
      if (w_tick_run) begin
        if (r_tick == TICK_LAST) begin
          r_tick <= '0;
          if (r_secs_left != 7'd0) r_secs_left <= r_secs_left - 7'd1;
        end else begin
          r_tick <= r_tick + TW'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (r_start_edge) begin
            r_level    <= w_mode_start;
            r_score    <= 8'd0;
            r_hs_mode  <= w_mode_start;
            r_hs_addr  <= r_lfsr[3:0];
            r_hs_start <= 1'b1;
            r_wd       <= 8'd0;
            r_status   <= 2'd1;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (hs.hs_en) begin
            r_state <= S_SHOW;
          end else if (w_wd_expired) begin
            r_hs_fault <= 1'b1;
            r_status   <= 2'd3;
            r_state    <= S_LOSE;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end
        S_SHOW: begin
          if (r_start_edge) begin
            r_hs_start <= 1'b1;
            r_wd       <= 8'd0;
            r_state    <= S_SCRAMBLE;
          end
        end
        S_SCRAMBLE: begin
          if (hs.hs_en) begin
            r_moves     <= 5'd0;
            r_secs_left <= SECS_INIT;
            r_tick      <= '0;
            r_state     <= S_PLAY;
          end else if (w_wd_expired) begin
            r_hs_fault <= 1'b1;
            r_status   <= 2'd3;
            r_state    <= S_LOSE;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end
        S_PLAY: begin
          if (r_secs_left == 7'd0) begin
            r_status <= 2'd3;
            r_state  <= S_LOSE;
          end else if (r_swap_edge && (r_moves != MOVES_MAX)) begin
            r_hs_change <= 1'b1;
            r_moves     <= r_moves + 5'd1;
            r_wd        <= 8'd0;
            r_state     <= S_SWAP;
          end
        end
        S_SWAP: begin
          if (hs.hs_en) begin
            r_win   <= 2'd0;
            r_state <= S_CHECK;
          end else if (w_wd_expired) begin
            r_hs_fault <= 1'b1;
            r_status   <= 2'd3;
            r_state    <= S_LOSE;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end
        S_CHECK: begin
          // Entry cycle is skipped so a stale isCorrect from the previous swap is ignored.
          if ((r_win != 2'd0) && hs.hs_correct) begin
            r_score  <= w_score_next;
            r_level  <= w_level_up;
            r_status <= 2'd2;
            r_state  <= S_WIN;
          end else if (r_win == 2'd3) begin
            if (r_moves == MOVES_MAX) begin
              r_status <= 2'd3;
              r_state  <= S_LOSE;
            end else begin
              r_state <= S_PLAY;
            end
          end else begin
            r_win <= r_win + 2'd1;
          end
        end
        S_WIN: begin
          if (r_start_edge) begin
            r_hs_mode  <= r_level;
            r_hs_addr  <= r_lfsr[3:0];
            r_hs_start <= 1'b1;
            r_wd       <= 8'd0;
            r_status   <= 2'd1;
            r_state    <= S_LOAD;
          end
        end
        S_LOSE: begin
          if (r_start_edge) begin
            r_hs_rst_n <= 1'b0;
            r_status   <= 2'd0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_status <= 2'd0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: two instances (long and short timing)
// driven against a small handler model that answers start/change strobes.
module tb_round_sequencer;

  logic       clk;
  logic       rst;
  logic       btn_start [2];
  logic       btn_swap  [2];
  logic [1:0] mode_sel  [2];
  logic [4:0] moves     [2];
  logic [6:0] secs      [2];
  logic [7:0] score     [2];
  logic [1:0] status    [2];
  logic       fault     [2];

  logic       hs_rst_n_w  [2];
  logic       hs_start_w  [2];
  logic       hs_change_w [2];
  logic [1:0] hs_mode_w   [2];
  logic [3:0] hs_addr_w   [2];

  logic [3:0] st_sr   [2];
  logic [3:0] ch_sr   [2];
  logic       auto_en [2];
  logic       ans     [2];

  logic [7:0] m_lfsr;
  logic [7:0] m_prev;

  int n_cmp;
  int n_fail;

  round_sequencer_if if0 ();
  round_sequencer_if if1 ();

  round_sequencer #(
    .TICK_DIV(1000), .MOVE_LIMIT(4), .ROUND_SECS(60), .LFSR_SEED(8'hA5), .HS_TIMEOUT(20)
  ) dut0 (
    .clk(clk), .rst(rst),
    .i_btn_start(btn_start[0]), .i_btn_swap(btn_swap[0]), .i_mode_sel(mode_sel[0]),
    .hs(if0),
    .o_moves(moves[0]), .o_secs_left(secs[0]), .o_score(score[0]),
    .o_status(status[0]), .o_hs_fault(fault[0])
  );

  round_sequencer #(
    .TICK_DIV(4), .MOVE_LIMIT(2), .ROUND_SECS(2), .LFSR_SEED(8'hA5), .HS_TIMEOUT(20)
  ) dut1 (
    .clk(clk), .rst(rst),
    .i_btn_start(btn_start[1]), .i_btn_swap(btn_swap[1]), .i_mode_sel(mode_sel[1]),
    .hs(if1),
    .o_moves(moves[1]), .o_secs_left(secs[1]), .o_score(score[1]),
    .o_status(status[1]), .o_hs_fault(fault[1])
  );

  assign hs_rst_n_w[0]  = if0.hs_rst_n;
  assign hs_rst_n_w[1]  = if1.hs_rst_n;
  assign hs_start_w[0]  = if0.hs_start;
  assign hs_start_w[1]  = if1.hs_start;
  assign hs_change_w[0] = if0.hs_change;
  assign hs_change_w[1] = if1.hs_change;
  assign hs_mode_w[0]   = if0.hs_mode;
  assign hs_mode_w[1]   = if1.hs_mode;
  assign hs_addr_w[0]   = if0.hs_addr;
  assign hs_addr_w[1]   = if1.hs_addr;

  // Handler model: en 4 cycles after start, en 2 after change, isCorrect 2 after that en.
  assign if0.hs_en      = st_sr[0][3] | ch_sr[0][1];
  assign if1.hs_en      = st_sr[1][3] | ch_sr[1][1];
  assign if0.hs_correct = ch_sr[0][3] & ans[0];
  assign if1.hs_correct = ch_sr[1][3] & ans[1];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        st_sr[d] <= 4'd0;
        ch_sr[d] <= 4'd0;
      end else begin
        st_sr[d] <= {st_sr[d][2:0], hs_start_w[d] & auto_en[d]};
        ch_sr[d] <= {ch_sr[d][2:0], hs_change_w[d]};
      end
    end
  end

  // Reference x^8+x^6+x^5+x^4+1 sequence; m_prev is the value a transition edge consumed.
  always @(posedge clk) begin
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_prev <= m_lfsr;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_start(input int d);
    btn_start[d] = 1'b1;
    @(negedge clk);
    btn_start[d] = 1'b0;
  endtask

  task automatic swap_pulse(input int d, input logic a, input int exp_moves);
    ans[d]      = a;
    btn_swap[d] = 1'b1;
    @(negedge clk);
    btn_swap[d] = 1'b0;
    @(negedge clk);
    chk("chg_pulse", hs_change_w[d], 1);
    chk("chg_moves", moves[d], exp_moves);
    @(negedge clk);
    chk("chg_once", hs_change_w[d], 0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      btn_start[d] = 1'b0;
      btn_swap[d]  = 1'b0;
      mode_sel[d]  = 2'd0;
      auto_en[d]   = 1'b1;
      ans[d]       = 1'b0;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_hs_rst_n", hs_rst_n_w[d], 0);
      chk("rst_hs_start", hs_start_w[d], 0);
      chk("rst_hs_change", hs_change_w[d], 0);
      chk("rst_hs_mode", hs_mode_w[d], 0);
      chk("rst_hs_addr", hs_addr_w[d], 0);
      chk("rst_moves", moves[d], 0);
      chk("rst_score", score[d], 0);
      chk("rst_status", status[d], 0);
      chk("rst_fault", fault[d], 0);
    end
    chk("rst_secs0", secs[0], 60);
    chk("rst_secs1", secs[1], 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_hs_rst_n0", hs_rst_n_w[0], 1);
    chk("rel_hs_rst_n1", hs_rst_n_w[1], 1);

    // Round 1 on dut0: level 1, three misses, then a hit exactly at the move limit.
    mode_sel[0] = 2'd1;
    press_start(0);
    @(negedge clk);
    chk("load_start", hs_start_w[0], 1);
    chk("load_mode", hs_mode_w[0], 1);
    chk("load_addr", hs_addr_w[0], m_prev[3:0]);
    chk("load_status", status[0], 1);
    @(negedge clk);
    chk("load_start_once", hs_start_w[0], 0);
    repeat (4) @(negedge clk);
    press_start(0);
    @(negedge clk);
    chk("scr_start", hs_start_w[0], 1);
    repeat (5) @(negedge clk);
    chk("play_moves", moves[0], 0);
    chk("play_secs", secs[0], 60);
    chk("play_status", status[0], 1);
    for (int i = 0; i < 3; i++) begin
      swap_pulse(0, 1'b0, i + 1);
      if (i == 1) begin
        btn_swap[0] = 1'b1;
        @(negedge clk);
        btn_swap[0] = 1'b0;
        @(negedge clk);
        chk("swap_drop", hs_change_w[0], 0);
        chk("swap_drop_moves", moves[0], 2);
        repeat (6) @(negedge clk);
      end else begin
        repeat (7) @(negedge clk);
      end
    end
    chk("moves3", moves[0], 3);
    chk("moves3_status", status[0], 1);
    swap_pulse(0, 1'b1, 4);
    repeat (3) @(negedge clk);
    chk("check_status", status[0], 1);
    @(negedge clk);
    chk("win_status", status[0], 2);
    chk("win_score", score[0], 2);
    chk("win_mode_held", hs_mode_w[0], 1);

    // Round 2 on dut0: level 2, four misses hit the move limit.
    press_start(0);
    @(negedge clk);
    chk("r2_start", hs_start_w[0], 1);
    chk("r2_mode", hs_mode_w[0], 2);
    chk("r2_addr", hs_addr_w[0], m_prev[3:0]);
    chk("r2_score", score[0], 2);
    chk("r2_status", status[0], 1);
    repeat (5) @(negedge clk);
    press_start(0);
    @(negedge clk);
    chk("r2_scr_start", hs_start_w[0], 1);
    repeat (5) @(negedge clk);
    chk("r2_moves_clr", moves[0], 0);
    for (int i = 0; i < 4; i++) begin
      swap_pulse(0, 1'b0, i + 1);
      if (i < 3) begin
        repeat (7) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
        chk("lim_check_status", status[0], 1);
        @(negedge clk);
        chk("lim_lose_status", status[0], 3);
        chk("lim_moves", moves[0], 4);
      end
    end
    press_start(0);
    @(negedge clk);
    chk("lose_hs_rst_n", hs_rst_n_w[0], 0);
    chk("lose_idle", status[0], 0);
    chk("idle_score_kept", score[0], 2);
    @(negedge clk);
    chk("lose_hs_rst_n_once", hs_rst_n_w[0], 1);

    // Watchdog: handler never answers the load.
    mode_sel[0] = 2'd3;
    auto_en[0]  = 1'b0;
    press_start(0);
    @(negedge clk);
    chk("wd_start", hs_start_w[0], 1);
    chk("wd_mode_clamp", hs_mode_w[0], 2);
    chk("wd_score_clr", score[0], 0);
    chk("wd_status", status[0], 1);
    repeat (19) @(negedge clk);
    chk("wd_wait_status", status[0], 1);
    chk("wd_wait_fault", fault[0], 0);
    @(negedge clk);
    chk("wd_lose", status[0], 3);
    chk("wd_fault", fault[0], 1);
    press_start(0);
    @(negedge clk);
    chk("wd_idle", status[0], 0);
    chk("wd_fault_idle", fault[0], 1);
    auto_en[0] = 1'b1;
    press_start(0);
    @(negedge clk);
    chk("wd_next_status", status[0], 1);
    chk("wd_fault_sticky", fault[0], 1);

    // dut1: 2 seconds of 4 cycles, round timeout then late win.
    press_start(1);
    @(negedge clk);
    chk("t_start", hs_start_w[1], 1);
    chk("t_mode", hs_mode_w[1], 0);
    chk("t_addr", hs_addr_w[1], m_prev[3:0]);
    repeat (5) @(negedge clk);
    press_start(1);
    @(negedge clk);
    chk("t_scr_start", hs_start_w[1], 1);
    repeat (5) @(negedge clk);
    chk("t_p1_secs", secs[1], 2);
    chk("t_p1_status", status[1], 1);
    repeat (3) @(negedge clk);
    chk("t_p4_secs", secs[1], 2);
    @(negedge clk);
    chk("t_p5_secs", secs[1], 1);
    repeat (3) @(negedge clk);
    chk("t_p8_secs", secs[1], 1);
    @(negedge clk);
    chk("t_p9_secs", secs[1], 0);
    chk("t_p9_status", status[1], 1);
    @(negedge clk);
    chk("t_lose", status[1], 3);
    press_start(1);
    @(negedge clk);
    chk("t_hs_rst_n", hs_rst_n_w[1], 0);
    chk("t_idle", status[1], 0);
    @(negedge clk);
    chk("t_hs_rst_n_once", hs_rst_n_w[1], 1);

    press_start(1);
    @(negedge clk);
    chk("t2_start", hs_start_w[1], 1);
    repeat (5) @(negedge clk);
    press_start(1);
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("t2_p1_secs", secs[1], 2);
    repeat (3) @(negedge clk);
    swap_pulse(1, 1'b1, 1);
    chk("t2_p7_secs", secs[1], 1);
    repeat (2) @(negedge clk);
    chk("t2_p9_secs", secs[1], 0);
    chk("t2_p9_status", status[1], 1);
    @(negedge clk);
    chk("t2_p10_status", status[1], 1);
    @(negedge clk);
    chk("t2_win", status[1], 2);
    chk("t2_score", score[1], 1);

    rst = 1'b0;
    @(negedge clk);
    chk("end_rst_fault", fault[0], 0);
    chk("end_rst_status", status[1], 0);
    chk("end_rst_score", score[1], 0);
    chk("end_rst_hs_rst_n", hs_rst_n_w[0], 0);
    rst = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
